// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, sequencer phases and
// the control strobe bundle used by control_unit and its decoder.
package risc_pkg;

   localparam int OPCODE_W = 3;
   localparam int PHASE_W  = 3;

   localparam logic [OPCODE_W-1:0] HLT = 3'd0;
   localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
   localparam logic [OPCODE_W-1:0] ADD = 3'd2;
   localparam logic [OPCODE_W-1:0] AND = 3'd3;
   localparam logic [OPCODE_W-1:0] XOR = 3'd4;
   localparam logic [OPCODE_W-1:0] LDA = 3'd5;
   localparam logic [OPCODE_W-1:0] STO = 3'd6;
   localparam logic [OPCODE_W-1:0] JMP = 3'd7;

   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic wr;
      logic data_e;
      logic halt;
   } strobes_t;

   // Opcodes whose operand is read from memory and lands in the accumulator.
   function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decoder: maps phase, halted state, opcode, zero flag
// and the advance enable onto the datapath control strobes.
module control_decode
   import risc_pkg::*;
(
   input  phase_e                phase,
   input  logic                  halted,
   input  logic [OPCODE_W-1:0]   opcode,
   input  logic                  zero,
   input  logic                  ena,
   output strobes_t              strobes
);

   logic aluop;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path can
      // leave a signal unassigned and infer a latch.
      strobes = '0;
      aluop   = is_aluop(opcode);

      if (halted) begin
         strobes.halt = 1'b1;
      end else begin
         unique case (phase)
            INST_ADDR:  strobes.sel = 1'b1;
            INST_FETCH: begin
               strobes.sel = 1'b1;
               strobes.rd  = 1'b1;
            end
            INST_LOAD: begin
               strobes.sel   = 1'b1;
               strobes.rd    = 1'b1;
               strobes.ld_ir = 1'b1;
            end
            IDLE: begin
               strobes.sel = 1'b1;
               strobes.rd  = 1'b1;
            end
            OP_ADDR: begin
               strobes.inc_pc = 1'b1;
               strobes.halt   = (opcode == HLT);
            end
            OP_FETCH:   strobes.rd = aluop;
            ALU_OP: begin
               strobes.rd     = aluop;
               strobes.inc_pc = (opcode == SKZ) && zero;
               strobes.ld_pc  = (opcode == JMP);
               strobes.data_e = (opcode == STO);
            end
            STORE: begin
               strobes.rd     = aluop;
               strobes.ld_ac  = aluop;
               strobes.ld_pc  = (opcode == JMP);
               strobes.data_e = (opcode == STO);
               strobes.wr     = (opcode == STO);
            end
            default: ;
         endcase

         // A stalled phase must not fire edge-acting strobes; bus-facing
         // signals stay decoded so address and data remain stable.
         if (!ena) begin
            strobes.ld_ir  = 1'b0;
            strobes.inc_pc = 1'b0;
            strobes.ld_pc  = 1'b0;
            strobes.ld_ac  = 1'b0;
            strobes.wr     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/control_unit.sv
// Eight-phase instruction sequencer for the 8-bit RISC core. Optional
// single-step gating of instruction start via `CTRL_SINGLE_STEP_EN.
module control_unit
   import risc_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                 step,
`endif
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic                 zero,
   output logic                 sel,
   output logic                 rd,
   output logic                 ld_ir,
   output logic                 inc_pc,
   output logic                 ld_pc,
   output logic                 ld_ac,
   output logic                 wr,
   output logic                 data_e,
   output logic                 halt,
   output logic [PHASE_W-1:0]   phase
);

   phase_e   phase_q, phase_d;
   logic     halted_q, halted_d;
   logic     advance;
   strobes_t strobes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      advance = ena;
`ifdef CTRL_SINGLE_STEP_EN
      // A new instruction only starts on a step pulse; once begun it runs
      // to completion on ena alone.
      if (phase_q == INST_ADDR) advance = ena & step;
`endif
      phase_d  = phase_q;
      halted_d = halted_q;

      if (!halted_q && advance) begin
         if (HALT_STICKY && (phase_q == OP_ADDR) && (opcode == HLT)) begin
            halted_d = 1'b1;
         end else begin
            phase_d = phase_e'(phase_q + 3'd1);
         end
      end
   end

   control_decode u_decode (
      .phase   (phase_q),
      .halted  (halted_q),
      .opcode  (opcode),
      .zero    (zero),
      .ena     (ena),
      .strobes (strobes)
   );

   assign sel    = strobes.sel;
   assign rd     = strobes.rd;
   assign ld_ir  = strobes.ld_ir;
   assign inc_pc = strobes.inc_pc;
   assign ld_pc  = strobes.ld_pc;
   assign ld_ac  = strobes.ld_ac;
   assign wr     = strobes.wr;
   assign data_e = strobes.data_e;
   assign halt   = strobes.halt;
   assign phase  = phase_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven instruction sequences
// through a scoreboard queue, plus hand-written halt, stall and reset cases.
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
`ifdef CTRL_SINGLE_STEP_EN
   logic       step;
`endif

   logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;
   logic ns_sel, ns_rd, ns_ld_ir, ns_inc_pc, ns_ld_pc, ns_ld_ac, ns_wr, ns_data_e, ns_halt;
   logic [2:0] ns_phase;

   control_unit #(.HALT_STICKY(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .opcode(opcode), .zero(zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
      .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
   );

   control_unit #(.HALT_STICKY(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .opcode(opcode), .zero(zero),
      .sel(ns_sel), .rd(ns_rd), .ld_ir(ns_ld_ir), .inc_pc(ns_inc_pc), .ld_pc(ns_ld_pc),
      .ld_ac(ns_ld_ac), .wr(ns_wr), .data_e(ns_data_e), .halt(ns_halt), .phase(ns_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e
   typedef struct {
      logic [7:0] strobes;
      logic       halt;
      logic [2:0] phase;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic       zero;
      logic       ena;
      exp_t       exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] dut_strobes();
      return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
   endfunction

   function automatic vec_t mk(input logic [2:0] op, input logic z, input logic e,
                               input logic [2:0] ph, input logic [7:0] s, input logic h);
      vec_t v;
      v.op = op; v.zero = z; v.ena = e;
      v.exp.strobes = s; v.exp.halt = h; v.exp.phase = ph;
      return v;
   endfunction

   task automatic compare_front(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_strobes"}, {24'd0, dut_strobes()}, {24'd0, e.strobes});
         check({tag, "_halt"},    {31'd0, halt},          {31'd0, e.halt});
         check({tag, "_phase"},   {29'd0, phase},         {29'd0, e.phase});
      end
   endtask

   // Drive one cycle's inputs, record the expectation, sample mid-cycle, advance.
   task automatic apply(input vec_t v, input string tag);
      opcode = v.op; zero = v.zero; ena = v.ena;
      sb.push_back(v.exp);
      #2;
      compare_front(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
      step = 1'b0;
`endif
      @(posedge clk);
      #2;
      check("rst_phase",   {29'd0, phase}, 32'd0);
      check("rst_strobes", {24'd0, dut_strobes()}, 32'h80);
      check("rst_halt",    {31'd0, halt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_fetch(input logic [2:0] op, input logic z);
      vecs.push_back(mk(op, z, 1'b1, 3'd0, 8'b1000_0000, 1'b0));
      vecs.push_back(mk(op, z, 1'b1, 3'd1, 8'b1100_0000, 1'b0));
      vecs.push_back(mk(op, z, 1'b1, 3'd2, 8'b1110_0000, 1'b0));
      vecs.push_back(mk(op, z, 1'b1, 3'd3, 8'b1100_0000, 1'b0));
      vecs.push_back(mk(op, z, 1'b1, 3'd4, 8'b0001_0000, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;

      // ADD with a one-cycle stall at INST_LOAD (ld_ir masked while stalled)
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd0, 8'b1000_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd1, 8'b1100_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b0, 3'd2, 8'b1100_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd2, 8'b1110_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd3, 8'b1100_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd4, 8'b0001_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd5, 8'b0100_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd6, 8'b0100_0000, 1'b0));
      vecs.push_back(mk(3'd2, 1'b0, 1'b1, 3'd7, 8'b0100_0100, 1'b0));
      // SKZ, zero=1: extra inc_pc in ALU_OP
      push_fetch(3'd1, 1'b1);
      vecs.push_back(mk(3'd1, 1'b1, 1'b1, 3'd5, 8'b0000_0000, 1'b0));
      vecs.push_back(mk(3'd1, 1'b1, 1'b1, 3'd6, 8'b0001_0000, 1'b0));
      vecs.push_back(mk(3'd1, 1'b1, 1'b1, 3'd7, 8'b0000_0000, 1'b0));
      // SKZ, zero=0; zero raised outside ALU_OP must have no effect
      push_fetch(3'd1, 1'b0);
      vecs.push_back(mk(3'd1, 1'b1, 1'b1, 3'd5, 8'b0000_0000, 1'b0));
      vecs.push_back(mk(3'd1, 1'b0, 1'b1, 3'd6, 8'b0000_0000, 1'b0));
      vecs.push_back(mk(3'd1, 1'b1, 1'b1, 3'd7, 8'b0000_0000, 1'b0));
      // STO
      push_fetch(3'd6, 1'b0);
      vecs.push_back(mk(3'd6, 1'b0, 1'b1, 3'd5, 8'b0000_0000, 1'b0));
      vecs.push_back(mk(3'd6, 1'b0, 1'b1, 3'd6, 8'b0000_0001, 1'b0));
      vecs.push_back(mk(3'd6, 1'b0, 1'b1, 3'd7, 8'b0000_0011, 1'b0));
      // JMP
      push_fetch(3'd7, 1'b0);
      vecs.push_back(mk(3'd7, 1'b0, 1'b1, 3'd5, 8'b0000_0000, 1'b0));
      vecs.push_back(mk(3'd7, 1'b0, 1'b1, 3'd6, 8'b0000_1000, 1'b0));
      vecs.push_back(mk(3'd7, 1'b0, 1'b1, 3'd7, 8'b0000_1000, 1'b0));
      // LDA with a three-cycle stall in STORE
      push_fetch(3'd5, 1'b0);
      vecs.push_back(mk(3'd5, 1'b0, 1'b1, 3'd5, 8'b0100_0000, 1'b0));
      vecs.push_back(mk(3'd5, 1'b0, 1'b1, 3'd6, 8'b0100_0000, 1'b0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(3'd5, 1'b0, 1'b0, 3'd7, 8'b0100_0000, 1'b0));
      vecs.push_back(mk(3'd5, 1'b0, 1'b1, 3'd7, 8'b0100_0100, 1'b0));
      vecs.push_back(mk(3'd5, 1'b0, 1'b1, 3'd0, 8'b1000_0000, 1'b0));

      do_reset();
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));
      check("sb_drained", sb.size(), 32'd0);

      // HLT: sticky instance freezes in OP_ADDR, non-sticky one moves on
      do_reset();
      opcode = 3'd0; zero = 1'b0; ena = 1'b1;
      for (int p = 0; p < 4; p++) begin
         #2;
         check("hlt_fetch_phase", {29'd0, phase}, p);
         check("hlt_fetch_halt",  {30'd0, halt, ns_halt}, 32'd0);
         @(posedge clk); #1;
      end
      #2;
      check("hlt_opaddr_phase",   {29'd0, phase}, 32'd4);
      check("hlt_opaddr_halt",    {30'd0, halt, ns_halt}, 32'd3);
      check("hlt_opaddr_strobes", {24'd0, dut_strobes()}, 32'h10);
      @(posedge clk); #1;
      #2;
      check("hlt_ns_phase", {29'd0, ns_phase}, 32'd5);
      check("hlt_ns_halt",  {31'd0, ns_halt}, 32'd0);
      for (int i = 0; i < 22; i++) begin
         ena = i[0];
         #1;
         check("halted_phase",   {29'd0, phase}, 32'd4);
         check("halted_halt",    {31'd0, halt}, 32'd1);
         check("halted_strobes", {24'd0, dut_strobes()}, 32'd0);
         @(posedge clk); #3;
      end
      do_reset();

      // Asynchronous reset in STORE of STO drops wr before any clock edge
      opcode = 3'd6; ena = 1'b1;
      for (int i = 0; i < 7; i++) @(posedge clk);
      #2;
      check("sto_pre_phase", {29'd0, phase}, 32'd7);
      check("sto_pre_wr",    {31'd0, wr}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_wr",    {31'd0, wr}, 32'd0);
      check("async_rst_phase", {29'd0, phase}, 32'd0);
      check("async_rst_sel",   {31'd0, sel}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
      // Single step: phase 0 holds until a step pulse, then one full instruction
      do_reset();
      opcode = 3'd2; ena = 1'b1; step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         check("step_hold", {29'd0, phase}, 32'd0);
      end
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      check("step_first", {29'd0, phase}, 32'd1);
      cnt = 1;
      while (phase != 3'd0 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("step_len", cnt, 32'd8);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         check("step_after", {29'd0, phase}, 32'd0);
      end
`else
      cnt = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
